// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the boot loader.
//   boot_state_e - loader sequencer states
//   WE_*         - Program_Memory byte-lane write enables
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        CHK,
        DRAIN,
        RUN,
        ERR
    } boot_state_e;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;

endpackage

// File: rtl/boot_loader.sv
// boot_loader: holds the core in reset, receives a program image as a byte
// stream (length byte, then low/high byte pairs per word) and writes it into
// Program_Memory one byte lane at a time, then releases the core.
//
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing checksum byte; the
// 8-bit sum of every received byte must be zero, otherwise the loader parks
// in ERR with the core held in reset.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start                - begin a load (honoured in IDLE, RUN, ERR)
//   in_data/in_valid     - stream byte and its valid
//   in_ready             - loader can take a byte this cycle
//   wr_addr/wr_data/we   - Program_Memory write port (registered)
//   cpu_reset            - processor reset, high unless in RUN
//   done                 - image loaded, core released
//   error                - checksum failure (tied low without BOOT_CHECKSUM_EN)
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [1:0]  we,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    boot_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;       // words remaining after the current one
    logic [7:0]  addr_q, addr_d;     // address of the word being received
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [1:0]  we_q, we_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        accept;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_next;
    logic       error_q, error_d;
`endif

    assign in_ready = (state_q == LEN) || (state_q == LO) ||
                      (state_q == HI)  || (state_q == CHK);
    assign accept   = in_valid && in_ready;

`ifdef BOOT_CHECKSUM_EN
    assign sum_next = sum_q + in_data;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we_d      = WE_NONE;

        case (state_q)
            IDLE: begin
                if (start) state_d = LEN;
            end
            LEN: begin
                if (accept) begin
                    // L = 0 encodes 256 words; 8-bit wrap of L - 1 gives 255.
                    cnt_d   = in_data - 8'd1;
                    addr_d  = BASE_ADDR;
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    we_d      = WE_LO;
                    wr_addr_d = addr_q;
                    wr_data_d = {8'h00, in_data};
                    state_d   = HI;
                end
            end
            HI: begin
                if (accept) begin
                    we_d      = WE_HI;
                    wr_addr_d = addr_q;
                    wr_data_d = {in_data, 8'h00};
                    if (cnt_q == 8'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + 8'd1;
                        state_d = LO;
                    end
                end
            end
            CHK: begin
`ifdef BOOT_CHECKSUM_EN
                if (accept) state_d = (sum_next == 8'h00) ? DRAIN : ERR;
`else
                state_d = IDLE;
`endif
            end
            DRAIN: begin
                state_d = RUN;
            end
            RUN: begin
                if (start) state_d = LEN;
            end
            ERR: begin
`ifdef BOOT_CHECKSUM_EN
                if (start) state_d = LEN;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        done_d      = (state_d == RUN);
        cpu_reset_d = (state_d != RUN);
    end

`ifdef BOOT_CHECKSUM_EN
    always_comb begin
        sum_d = sum_q;
        if (accept) sum_d = (state_q == LEN) ? in_data : sum_next;
        error_d = (state_d == ERR);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= BASE_ADDR;
            wr_addr_q   <= BASE_ADDR;
            wr_data_q   <= 16'h0000;
            we_q        <= WE_NONE;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= 8'h00;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= sum_d;
            error_q     <= error_d;
`endif
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign we        = we_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
`ifdef BOOT_CHECKSUM_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: two loaders (base 8'h00 and 8'h80) share one randomized
// stream; a transaction-level model predicts every output each cycle, and a
// few literal write logs pin the model. Honours BOOT_CHECKSUM_EN.
module tb_boot_loader;

    localparam logic [7:0] BASE_A = 8'h00;
    localparam logic [7:0] BASE_B = 8'h80;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        a_in_ready, a_cpu_reset, a_done, a_error;
    logic [7:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic [1:0]  a_we;
    logic        b_in_ready, b_cpu_reset, b_done, b_error;
    logic [7:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic [1:0]  b_we;

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(BASE_A)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(a_in_ready), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .we(a_we), .cpu_reset(a_cpu_reset),
        .done(a_done), .error(a_error)
    );

    boot_loader #(.BASE_ADDR(BASE_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(b_in_ready), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .we(b_we), .cpu_reset(b_cpu_reset),
        .done(b_done), .error(b_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_RUN = 3, M_ERR = 4;
    int          m_mode;
    int          m_k;      // bytes accepted in this load (0 = length byte next)
    int          m_n;      // word count
    logic [7:0]  m_sum;
    logic [7:0]  e_widx;   // word index of the last write
    logic [15:0] e_wdata;
    logic [1:0]  e_we;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_k     = 0;
        m_n     = 0;
        m_sum   = 8'h00;
        e_widx  = 8'h00;
        e_wdata = 16'h0000;
        e_we    = 2'b00;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d);
        int j;
        e_we = 2'b00;
        case (m_mode)
            M_IDLE, M_RUN, M_ERR: if (s) begin m_mode = M_LOAD; m_k = 0; end
            M_LOAD: if (v) begin
                if (m_k == 0) begin
                    m_n   = (d == 8'h00) ? 256 : int'(d);
                    m_sum = d;
                end else if (m_k <= 2 * m_n) begin
                    j       = m_k - 1;
                    e_widx  = 8'(j / 2);
                    e_we    = (j % 2 == 0) ? 2'b01 : 2'b10;
                    e_wdata = (j % 2 == 0) ? {8'h00, d} : {d, 8'h00};
                    m_sum   = m_sum + d;
                end else begin
                    m_sum = m_sum + d;
                end
                m_k++;
                if (!CHK_EN && m_k == 2 * m_n + 1) m_mode = M_DRAIN;
                else if (CHK_EN && m_k == 2 * m_n + 2)
                    m_mode = (m_sum == 8'h00) ? M_DRAIN : M_ERR;
            end
            M_DRAIN: m_mode = M_RUN;
            default: m_mode = M_IDLE;
        endcase
    endtask

    logic [25:0] log_a[$];
    logic [25:0] log_b[$];

    // Single compare process: model advances on each edge, outputs checked 2 units later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step(start, in_valid, in_data);
            #2;
            chk("a_in_ready", a_in_ready, m_mode == M_LOAD);
            chk("a_cpu_reset", a_cpu_reset, m_mode != M_RUN);
            chk("a_done", a_done, m_mode == M_RUN);
            chk("a_error", a_error, m_mode == M_ERR);
            chk("a_we", a_we, e_we);
            chk("a_wr_addr", a_wr_addr, 8'(BASE_A + e_widx));
            chk("a_wr_data", a_wr_data, e_wdata);
            chk("b_in_ready", b_in_ready, m_mode == M_LOAD);
            chk("b_cpu_reset", b_cpu_reset, m_mode != M_RUN);
            chk("b_done", b_done, m_mode == M_RUN);
            chk("b_error", b_error, m_mode == M_ERR);
            chk("b_we", b_we, e_we);
            chk("b_wr_addr", b_wr_addr, 8'(BASE_B + e_widx));
            chk("b_wr_data", b_wr_data, e_wdata);
            if (a_we != 2'b00) log_a.push_back({a_wr_addr, a_we, a_wr_data});
            if (b_we != 2'b00) log_b.push_back({b_wr_addr, b_we, b_wr_data});
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] img[$];

    task automatic send_byte(input logic [7:0] d, input bit gaps);
        bit sent;
        int tries;
        sent  = 1'b0;
        tries = 0;
        while (!sent) begin
            @(negedge clk);
            in_data  = d;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            // Stray starts mid-load must be ignored.
            start    = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (in_valid && a_in_ready) sent = 1'b1;
            tries++;
            if (tries > 200) begin
                $display("FAIL send_byte_timeout: got no handshake expected handshake");
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
                $fatal(1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = $urandom_range(0, 1);
            in_data  = 8'($urandom);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
    endtask

    // Sends img, appending a good or corrupted checksum when the feature is built in.
    task automatic send_img(input bit gaps, input bit good);
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) s = s + img[i];
        if (CHK_EN) img.push_back(good ? 8'(8'h00 - s) : 8'(8'h01 - s));
        foreach (img[i]) send_byte(img[i], gaps);
        idle(4);
    endtask

    task automatic random_img(input int len);
        img.delete();
        img.push_back(8'(len));
        for (int i = 0; i < 2 * ((len == 0) ? 256 : len); i++) img.push_back(8'($urandom));
    endtask

    task automatic check_fixed_log(input string tag);
        chk({tag, "_count"}, log_a.size(), 4);
        if (log_a.size() == 4) begin
            chk({tag, "_w0"}, log_a[0], {8'h00, 2'b01, 16'h0034});
            chk({tag, "_w1"}, log_a[1], {8'h00, 2'b10, 16'h1200});
            chk({tag, "_w2"}, log_a[2], {8'h01, 2'b01, 16'h0078});
            chk({tag, "_w3"}, log_a[3], {8'h01, 2'b10, 16'h5600});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", a_cpu_reset, 1'b1);
        chk("rst_done", a_done, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_wr_addr_b", b_wr_addr, 8'h80);
        reset = 1'b0;
        idle(3);

        // Fixed image, full throughput.
        log_a.delete(); log_b.delete();
        pulse_start();
        img = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
        send_img(1'b0, 1'b1);
        check_fixed_log("fixed");
        chk("fixed_done", a_done, 1'b1);
        chk("fixed_cpu_reset", a_cpu_reset, 1'b0);

        // Same image with gaps, restarted from RUN.
        log_a.delete(); log_b.delete();
        pulse_start();
        img = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
        send_img(1'b1, 1'b1);
        check_fixed_log("gaps");

        // L = 0: 256 words, B wraps 80..FF, 00..7F.
        log_a.delete(); log_b.delete();
        pulse_start();
        random_img(0);
        send_img(1'b1, 1'b1);
        chk("wrap_count", log_b.size(), 512);
        if (log_b.size() == 512) begin
            chk("wrap_first_addr", log_b[0][25:18], 8'h80);
            chk("wrap_ff_addr", log_b[255][25:18], 8'hFF);
            chk("wrap_00_addr", log_b[256][25:18], 8'h00);
            chk("wrap_last_addr", log_b[511][25:18], 8'h7F);
            chk("wrap_last_we", log_b[511][17:16], 2'b10);
        end
        chk("wrap_done", b_done, 1'b1);

`ifdef BOOT_CHECKSUM_EN
        pulse_start();
        img = '{8'h01, 8'hAA, 8'h55};
        send_img(1'b0, 1'b1);
        chk("chk_good_done", a_done, 1'b1);
        chk("chk_good_error", a_error, 1'b0);
        pulse_start();
        img = '{8'h01, 8'hAA, 8'h55};
        send_img(1'b0, 1'b0);
        chk("chk_bad_error", a_error, 1'b1);
        chk("chk_bad_cpu_reset", a_cpu_reset, 1'b1);
        chk("chk_bad_done", a_done, 1'b0);
`endif

        // Reset after three data bytes.
        pulse_start();
        random_img(5);
        for (int i = 0; i < 4; i++) send_byte(img[i], 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_in_ready", a_in_ready, 1'b0);
        chk("midrst_cpu_reset", a_cpu_reset, 1'b1);
        chk("midrst_done", a_done, 1'b0);
        chk("midrst_we", a_we, 2'b00);
        chk("midrst_wr_addr_a", a_wr_addr, 8'h00);
        chk("midrst_wr_data", a_wr_data, 16'h0000);
        chk("midrst_wr_addr_b", b_wr_addr, 8'h80);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2);
        log_a.delete(); log_b.delete();
        pulse_start();
        random_img(5);
        send_img(1'b1, 1'b1);
        chk("reload_count", log_a.size(), 10);
        chk("reload_done", a_done, 1'b1);

        // Random images back to back.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 12);
            log_a.delete(); log_b.delete();
            pulse_start();
            random_img(len);
            send_img(1'b1, 1'b1);
            chk("rand_count", log_a.size(), 2 * len);
            idle($urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
